instruction_fetch: RTL
======================

# instruction_fetch

Dual-issue fetch stage feeding the decode/hazard stage. Holds the PC and a local instruction memory, and presents one aligned instruction pair per cycle together with its PC and a single-slot marker. It replays the previous pair when decode raises `stall`, and redirects on a taken branch. It is the producer end of the decode stage's `instruction_in1`/`instruction_in2`/`PC_pass_in`/`find_nop`/`stall` interface.

## Interface
Parameters:
- `IMEM_DEPTH`, default 1024: instruction memory depth in 32-bit words. It equals 2^10, the full PC range.

Ports. Bit order is `[0:N]`, with bit N the LSB.
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `imem_wr_en`, in, 1: program-load write strobe.
- `imem_wr_addr`, in, 10: program-load word address.
- `imem_wr_data`, in, 32: program-load word.
- `stall`, in, 1: registered stall from decode. It refers to the pair presented in the previous cycle.
- `branch_taken`, in, 1: redirect request from the branch unit.
- `branch_target`, in, 10: redirect word address.
- `instruction_out1`, out, 32: first slot of the pair (even word address).
- `instruction_out2`, out, 32: second slot (odd word address).
- `PC_out`, out, 10: word address of `instruction_out1` slot, always even.
- `find_nop`, out, 1: only slot 2 holds a real instruction.
- `fetch_valid`, out, 1: the pair is real fetched data, not reset filler.

## Operation
- Memory is combinational-read. A write and a read to the same address in one cycle return the old data.
- Internal state:
  - `pc`: next pair address, even.
  - `prev` pair: instr1, instr2, PC, `find_nop`, valid.
  - `redirect_d` flag.
- Per-edge priority, highest first:
  1. `rst_n` low: reset.
  2. `branch_taken`: redirect.
  3. `stall` while `redirect_d`=0: replay.
  4. Otherwise: advance.
- **Advance:**
  - outputs <= {mem[pc], mem[pc+1], pc, 0, 1}
  - `prev` <= current outputs
  - `pc` <= pc+2
- **Redirect:** let a = `branch_target` with bit 9 cleared.
  - If target bit 9 = 0: outputs <= {mem[a], mem[a+1], a, 0, 1}.
  - If target bit 9 = 1: outputs <= {NOP_WORD, mem[target], a, 1, 1}.
  - `prev` <= the new outputs, `pc` <= a+2, `redirect_d` <= 1.
- **Replay:**
  - outputs <= `prev`; `prev` unchanged.
  - `pc` <= `prev` PC + 2.
  - Consecutive stalls keep re-presenting the same pair.
- `redirect_d` clears on any non-redirect edge. A `stall` seen in the cycle right after a redirect refers to a killed pair and is ignored. That edge advances.
- Reset values:
  - `instruction_out1` = NOP_WORD (0x40200000)
  - `instruction_out2` = LNOP_WORD (0x00200000)
  - `PC_out` = 0, `find_nop` = 0, `fetch_valid` = 0
  - `pc` = 0, `prev` = same filler pair, `redirect_d` = 0
  - Memory contents are not reset.
- PC arithmetic is modulo 1024, so 1022+2 wraps to 0.

## Timing
- Fetch latency is one edge from `pc` to the output registers. All outputs are registered.
- The first edge after reset release presents pair 0 with `fetch_valid` = 1.
- `branch_taken` at edge e puts the target pair on the outputs after e, with zero bubble. Killing the pair presented during cycle e is decode's responsibility.
- A `stall` high in cycle t makes the outputs after edge t equal those of cycle t-1.
- Reset mid-operation immediately forces the reset values, asynchronously, and discards any pending redirect or replay.

## Structure
- NOP_WORD and LNOP_WORD constants go in `opcode_package.vh` with the existing instruction IDs, shared with decode.
- Sub-module `instr_mem`:
  - `IMEM_DEPTH` x 32 array
  - one synchronous write port
  - one dual-word combinational read port (addr, addr+1)
- Everything else lives in `instruction_fetch`: PC, `prev` register, redirect flag, output registers.

## Test plan
- **Reset and stream:** load mem[k] = k. Hold reset, then release.
  - Outputs during reset: 0x40200000 / 0x00200000 / PC 0 / valid 0.
  - Then pairs (0,1) PC 0, (2,3) PC 2, (4,5) PC 4.
- **Single stall:** stall high for one cycle while (4,5) is presented. Following outputs: (2,3) PC 2, then (4,5), then (6,7).
- **Back-to-back stall:** stall high for 2 cycles. (2,3) is presented twice, then (4,5).
- **Odd-target redirect:** `branch_taken` with target 11. Outputs: (0x40200000, 11) PC 10 `find_nop` 1, then (12,13) PC 12. A stall in the next cycle is ignored.
- **Redirect beats stall:** `branch_taken` (target 20) and stall in the same cycle. Outputs: (20,21) PC 20, then (22,23).
- **Wrap and async reset:** target 1022 gives (1022,1023), then (0,1). Drop `rst_n` mid-cycle: outputs return to reset values before the next edge.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared fetch constants and the presented-pair record
package instruction_fetch_pkg;

    localparam int PC_W = 10;

    // Filler words shared with decode: NOP for the even pipe, LNOP for the odd pipe.
    localparam logic [31:0] NOP_WORD  = 32'h4020_0000;
    localparam logic [31:0] LNOP_WORD = 32'h0020_0000;

    typedef struct packed {
        logic [31:0]     instr1;
        logic [31:0]     instr2;
        logic [PC_W-1:0] pc;
        logic            find_nop;
        logic            valid;
    } fetch_pair_t;

    localparam fetch_pair_t FILLER_PAIR = '{
        instr1:   NOP_WORD,
        instr2:   LNOP_WORD,
        pc:       '0,
        find_nop: 1'b0,
        valid:    1'b0
    };

endpackage

// File: rtl/instruction_fetch_instr_mem.sv
// rtl/instruction_fetch_instr_mem.sv - instruction memory, one write port, dual-word combinational read
module instr_mem #(
    parameter int IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        i_wr_en,
    input  logic [9:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic [9:0]  i_rd_addr,
    output logic [31:0] o_rd_data1,
    output logic [31:0] o_rd_data2
);

    logic [31:0] r_mem [IMEM_DEPTH];
    logic [9:0]  w_rd_addr2;

    // A same-cycle write is only visible after the edge, so reads see the old word.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_rd_addr2 = i_rd_addr + 10'd1;
    assign o_rd_data1 = r_mem[i_rd_addr];
    assign o_rd_data2 = r_mem[w_rd_addr2];

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - dual-issue fetch stage with stall replay and branch redirect
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imem_wr_en,
    input  logic [0:9]  imem_wr_addr,
    input  logic [0:31] imem_wr_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [0:9]  branch_target,
    output logic [0:31] instruction_out1,
    output logic [0:31] instruction_out2,
    output logic [0:9]  PC_out,
    output logic        find_nop,
    output logic        fetch_valid
);

    logic [PC_W-1:0] r_pc;
    logic            r_redirect_d;
    fetch_pair_t     r_out;
    fetch_pair_t     r_prev;

    logic [PC_W-1:0] w_tgt;
    logic [PC_W-1:0] w_tgt_even;
    logic [PC_W-1:0] w_rd_addr;
    logic [PC_W-1:0] w_wr_addr;
    logic [31:0]     w_wr_data;
    logic [31:0]     w_rd1;
    logic [31:0]     w_rd2;
    fetch_pair_t     w_fetch;

    assign w_tgt      = branch_target;
    assign w_tgt_even = {w_tgt[PC_W-1:1], 1'b0};
    assign w_rd_addr  = branch_taken ? w_tgt_even : r_pc;
    assign w_wr_addr  = imem_wr_addr;
    assign w_wr_data  = imem_wr_data;

    instr_mem #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_instr_mem (
        .clk        (clk),
        .i_wr_en    (imem_wr_en),
        .i_wr_addr  (w_wr_addr),
        .i_wr_data  (w_wr_data),
        .i_rd_addr  (w_rd_addr),
        .o_rd_data1 (w_rd1),
        .o_rd_data2 (w_rd2)
    );

    // An odd branch target lands mid-pair: slot 1 becomes filler and decode is told via find_nop.
    always_comb begin
        w_fetch          = '0;
        w_fetch.instr1   = w_rd1;
        w_fetch.instr2   = w_rd2;
        w_fetch.pc       = w_rd_addr;
        w_fetch.find_nop = 1'b0;
        w_fetch.valid    = 1'b1;
        if (branch_taken && w_tgt[0]) begin
            w_fetch.instr1   = NOP_WORD;
            w_fetch.find_nop = 1'b1;
        end
    end

    // A stall right after a redirect refers to a pair decode has already killed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= '0;
            r_redirect_d <= 1'b0;
            r_out        <= FILLER_PAIR;
            r_prev       <= FILLER_PAIR;
        end else if (branch_taken) begin
            r_out        <= w_fetch;
            r_prev       <= w_fetch;
            r_pc         <= w_tgt_even + 10'd2;
            r_redirect_d <= 1'b1;
        end else if (stall && !r_redirect_d) begin
            r_out        <= r_prev;
            r_pc         <= r_prev.pc + 10'd2;
            r_redirect_d <= 1'b0;
        end else begin
            r_out        <= w_fetch;
            r_prev       <= r_out;
            r_pc         <= r_pc + 10'd2;
            r_redirect_d <= 1'b0;
        end
    end

    assign instruction_out1 = r_out.instr1;
    assign instruction_out2 = r_out.instr2;
    assign PC_out           = r_out.pc;
    assign find_nop         = r_out.find_nop;
    assign fetch_valid      = r_out.valid;

endmodule
